// File: rtl/pi_theta_feeder.sv
// Theta-PI integrator feeder: buffers one float sample per turbine, then per control
// step issues done_read_x, a sta-led N-word x stream, and waits for the integrator's done_sig.
module pi_theta_feeder #(
  parameter int N       = 4,
  parameter int LEAD    = 15,
  parameter int TIMEOUT = 64,
  parameter int WIDTH   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             step,
  input  logic             err_clr,
  output logic             done_read_x,
  output logic             sta,
  output logic [WIDTH-1:0] x,
  input  logic             done_sig,
  output logic             step_done,
  output logic             busy,
  output logic             err_step,
  output logic             err_timeout
);

  localparam int CW = 10;
  localparam int WW = $clog2(N + 1);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [2:0] {S_FILL, S_READY, S_LEAD, S_STREAM, S_WAIT, S_DRAIN} state_t;

  state_t           state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [WW-1:0]    wcnt, wcnt_n;
  logic             armed;
  logic             wr, step_bad, tmo;
  logic [WIDTH-1:0] slot [N];

  assign wr = in_valid && in_ready;

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    wcnt_n   = wcnt;
    tmo      = 1'b0;
    step_bad = step && (state != S_READY);
    case (state)
      S_FILL: if (wr) begin
        wcnt_n = wcnt + WW'(1);
        if (wcnt == WW'(N - 1)) state_n = S_READY;
      end
      S_READY: if (step) begin
        state_n = S_LEAD;
        cnt_n   = '0;
      end
      S_LEAD: if (cnt == CW'(LEAD - 1)) begin
        state_n = S_STREAM;
        cnt_n   = '0;
      end else cnt_n = cnt + CW'(1);
      S_STREAM: if (cnt == CW'(N - 1)) begin
        state_n = S_WAIT;
        cnt_n   = '0;
      end else cnt_n = cnt + CW'(1);
      S_WAIT: if (done_sig) begin
        state_n = S_DRAIN;
        cnt_n   = '0;
      end else if (cnt == CW'(TIMEOUT - 1)) begin
        // done_sig took priority above, so expiry only aborts when it is truly missing
        tmo     = 1'b1;
        state_n = S_FILL;
        cnt_n   = '0;
        wcnt_n  = '0;
      end else cnt_n = cnt + CW'(1);
      S_DRAIN: if (cnt == CW'(N - 1)) begin
        state_n = S_FILL;
        cnt_n   = '0;
        wcnt_n  = '0;
      end else cnt_n = cnt + CW'(1);
      default: state_n = S_FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_FILL;
      cnt         <= '0;
      wcnt        <= '0;
      armed       <= 1'b0;
      err_step    <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      wcnt        <= wcnt_n;
      armed       <= 1'b1;
      err_step    <= step_bad | (err_step    & ~err_clr);
      err_timeout <= tmo      | (err_timeout & ~err_clr);
    end
  end

  // sample buffer holds no reset: contents are only read after a full fill
  always_ff @(posedge clk) begin
    if (wr) slot[wcnt[IW-1:0]] <= in_data;
  end

  // armed keeps in_ready low while reset is held, even though the FSM sits in FILL
  assign in_ready    = armed && (state == S_FILL);
  assign done_read_x = (state == S_LEAD) && (cnt == '0);
  assign sta         = (state == S_STREAM) && (cnt == '0);
  assign x           = (state == S_STREAM) ? slot[cnt[IW-1:0]] : '0;
  assign step_done   = (state == S_DRAIN) && (cnt == CW'(N - 1));
  assign busy        = state inside {S_LEAD, S_STREAM, S_WAIT, S_DRAIN};

endmodule

// File: tb/tb_pi_theta_feeder.sv
// Bench for pi_theta_feeder: timeline model computed from step/done_sig cycle offsets
// and a buffer model that keeps the first N samples accepted after each empty.
module tb_pi_theta_feeder;
  localparam int N = 4, LEAD = 15, TIMEOUT = 64, W = 32;

  logic clk = 1'b0, rst = 1'b0;
  logic in_valid = 1'b0, step = 1'b0, err_clr = 1'b0, done_sig = 1'b0;
  logic [W-1:0] in_data = '0;
  logic in_ready, done_read_x, sta, step_done, busy, err_step, err_timeout;
  logic [W-1:0] x;

  int vecs = 0, errs = 0;
  logic [W-1:0] mbuf [N];
  int mcnt = 0;
  logic [W-1:0] wq [$];

  pi_theta_feeder #(.N(N), .LEAD(LEAD), .TIMEOUT(TIMEOUT), .WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .step(step), .err_clr(err_clr), .done_read_x(done_read_x), .sta(sta), .x(x),
    .done_sig(done_sig), .step_done(step_done), .busy(busy),
    .err_step(err_step), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // back-to-back writes of wq; the model keeps only the first N since the buffer emptied
  task automatic write_wq();
    foreach (wq[i]) begin
      in_valid = 1'b1; in_data = wq[i];
      if (mcnt < N) begin mbuf[mcnt] = wq[i]; mcnt++; end
      tick();
    end
    in_valid = 1'b0; in_data = '0;
  endtask

  task automatic fill_rand(input int n);
    wq.delete();
    for (int i = 0; i < n; i++) wq.push_back({16'($urandom), 16'(i)});
    write_wq();
  endtask

  task automatic pulse_step();
    step = 1'b1; tick(); step = 1'b0;
  endtask

  task automatic close_step();
    done_sig = 1'b1; tick(); done_sig = 1'b0;
    repeat (N) tick();
    mcnt = 0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick(); tick();
    vecs++;
    if ({in_ready, done_read_x, sta, step_done, busy, err_step, err_timeout} !== 7'b0 || x !== '0) begin
      errs++;
      $display("FAIL reset_outputs got rdy=%b drx=%b sta=%b sd=%b busy=%b es=%b et=%b x=%h want all 0",
               in_ready, done_read_x, sta, step_done, busy, err_step, err_timeout, x);
    end
    rst = 1'b1;
    tick();
    vecs++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errs++; $display("FAIL reset_release got rdy=%b busy=%b want rdy=1 busy=0", in_ready, busy);
    end
  endtask

  task automatic test_stream();
    logic [W-1:0] ex;
    wq = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
    write_wq();
    pulse_step();
    for (int c = 1; c <= LEAD + N + 1; c++) begin
      ex = (c > LEAD && c <= LEAD + N) ? mbuf[c-LEAD-1] : '0;
      vecs++;
      if (done_read_x !== (c == 1) || sta !== (c == LEAD + 1) || x !== ex || busy !== 1'b1) begin
        errs++;
        $display("FAIL stream c=%0d got drx=%b sta=%b x=%h busy=%b want drx=%b sta=%b x=%h busy=1",
                 c, done_read_x, sta, x, busy, c == 1, c == LEAD + 1, ex);
      end
      tick();
    end
    close_step();
  endtask

  task automatic test_completion(input int k);
    logic [W-1:0] ex;
    fill_rand(N);
    pulse_step();
    for (int c = 1; c <= LEAD + N; c++) begin
      ex = (c > LEAD) ? mbuf[c-LEAD-1] : '0;
      vecs++;
      if (sta !== (c == LEAD + 1) || x !== ex) begin
        errs++;
        $display("FAIL repeat_timing c=%0d got sta=%b x=%h want sta=%b x=%h", c, sta, x, c == LEAD + 1, ex);
      end
      tick();
    end
    repeat (k) tick();
    done_sig = 1'b1; tick(); done_sig = 1'b0;
    for (int c = 1; c <= N + 1; c++) begin
      vecs++;
      if (step_done !== (c == N) || busy !== (c <= N) || in_ready !== (c == N + 1)) begin
        errs++;
        $display("FAIL completion k=%0d c=%0d got sd=%b busy=%b rdy=%b want sd=%b busy=%b rdy=%b",
                 k, c, step_done, busy, in_ready, c == N, c <= N, c == N + 1);
      end
      tick();
    end
    mcnt = 0;
  endtask

  task automatic test_rejects();
    logic [W-1:0] ex, w;
    fill_rand(2);
    pulse_step();
    vecs++;
    if (err_step !== 1'b1 || done_read_x !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      errs++;
      $display("FAIL reject_fill got es=%b drx=%b busy=%b rdy=%b want 1 0 0 1", err_step, done_read_x, busy, in_ready);
    end
    fill_rand(2);
    pulse_step();
    for (int c = 1; c <= LEAD + N; c++) begin
      ex = (c > LEAD) ? mbuf[c-LEAD-1] : '0;
      vecs++;
      if (x !== ex || sta !== (c == LEAD + 1) || err_step !== 1'b1) begin
        errs++;
        $display("FAIL reject_stream c=%0d got x=%h sta=%b es=%b want x=%h sta=%b es=1", c, x, sta, err_step, ex, c == LEAD + 1);
      end
      step = (c == LEAD + 2);
      tick();
    end
    step = 1'b0;
    close_step();
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    vecs++;
    if (err_step !== 1'b0) begin errs++; $display("FAIL err_clr got es=%b want 0", err_step); end
    fill_rand(N - 1);
    // step and err_clr both land on the cycle of the Nth write
    w = 32'h7FC00001;
    in_valid = 1'b1; in_data = w; step = 1'b1; err_clr = 1'b1;
    mbuf[mcnt] = w; mcnt++;
    tick();
    in_valid = 1'b0; in_data = '0; step = 1'b0; err_clr = 1'b0;
    vecs++;
    if (err_step !== 1'b1 || in_ready !== 1'b0 || done_read_x !== 1'b0) begin
      errs++;
      $display("FAIL step_on_last_write got es=%b rdy=%b drx=%b want 1 0 0", err_step, in_ready, done_read_x);
    end
    pulse_step();
    vecs++;
    if (done_read_x !== 1'b1) begin errs++; $display("FAIL step_after_full got drx=%b want 1", done_read_x); end
    repeat (LEAD + N) tick();
    close_step();
    err_clr = 1'b1; tick(); err_clr = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [W-1:0] ex;
    wq.delete();
    wq.push_back(32'h7FC00001);
    wq.push_back(32'h00000001);
    for (int i = 2; i < 6; i++) wq.push_back({16'($urandom), 16'(i)});
    write_wq();
    vecs++;
    if (in_ready !== 1'b0) begin errs++; $display("FAIL bp_ready got rdy=%b want 0", in_ready); end
    pulse_step();
    for (int c = 1; c <= LEAD + N + 1; c++) begin
      ex = (c > LEAD && c <= LEAD + N) ? mbuf[c-LEAD-1] : '0;
      vecs++;
      if (x !== ex) begin errs++; $display("FAIL bp_stream c=%0d got x=%h want x=%h", c, x, ex); end
      tick();
    end
    close_step();
  endtask

  task automatic test_timeout();
    done_sig = 1'b1; tick(); done_sig = 1'b0;
    fill_rand(N);
    pulse_step();
    repeat (LEAD + N) tick();
    repeat (TIMEOUT - 1) tick();
    vecs++;
    if (busy !== 1'b1 || err_timeout !== 1'b0 || err_step !== 1'b0) begin
      errs++;
      $display("FAIL timeout_last_wait got busy=%b et=%b es=%b want 1 0 0", busy, err_timeout, err_step);
    end
    tick();
    vecs++;
    if (err_timeout !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b1) begin
      errs++;
      $display("FAIL timeout_abort got et=%b busy=%b rdy=%b want 1 0 1", err_timeout, busy, in_ready);
    end
    mcnt = 0;
    for (int c = 0; c < 6; c++) begin
      vecs++;
      if (step_done !== 1'b0) begin errs++; $display("FAIL timeout_no_done c=%0d got sd=%b want 0", c, step_done); end
      tick();
    end
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    vecs++;
    if (err_timeout !== 1'b0) begin errs++; $display("FAIL timeout_clr got et=%b want 0", err_timeout); end
    fill_rand(N);
    pulse_step();
    repeat (LEAD + N + TIMEOUT - 1) tick();
    done_sig = 1'b1; tick(); done_sig = 1'b0;
    for (int c = 1; c <= N + 1; c++) begin
      vecs++;
      if (step_done !== (c == N) || err_timeout !== 1'b0) begin
        errs++;
        $display("FAIL done_at_expiry c=%0d got sd=%b et=%b want sd=%b et=0", c, step_done, err_timeout, c == N);
      end
      tick();
    end
    mcnt = 0;
  endtask

  task automatic test_reset_mid();
    fill_rand(N);
    pulse_step();
    pulse_step();
    tick();
    rst = 1'b0;
    #1;
    vecs++;
    if ({in_ready, done_read_x, sta, step_done, busy, err_step, err_timeout} !== 7'b0 || x !== '0) begin
      errs++;
      $display("FAIL reset_mid got rdy=%b drx=%b sta=%b sd=%b busy=%b es=%b et=%b x=%h want all 0",
               in_ready, done_read_x, sta, step_done, busy, err_step, err_timeout, x);
    end
    tick(); tick();
    rst = 1'b1;
    mcnt = 0;
    tick();
    for (int c = 0; c < LEAD + N + 10; c++) begin
      vecs++;
      if (sta !== 1'b0 || step_done !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
        errs++;
        $display("FAIL reset_after c=%0d got sta=%b sd=%b busy=%b rdy=%b want 0 0 0 1", c, sta, step_done, busy, in_ready);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_completion($urandom_range(0, 20));
    test_completion($urandom_range(0, TIMEOUT - 2));
    test_rejects();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/pi_theta_feeder.md
Name: pi_theta_feeder

Overview:
- Upstream sequencer for the time-multiplexed theta PI integrator.
- Collects one IEEE-754 single error sample per wind turbine into an N-word buffer.
- On each control step, issues the integrator's early read strobe (done_read_x), then the sta pulse followed by a contiguous N-word x stream.
- Tracks the integrator's returning done_sig to close the step, and flags protocol errors.

Parameters:
- N, 4, number of turbines multiplexed per step; instantiated with `N_WindTurbine; legal range 1..16.
- LEAD, 15, cycles from done_read_x to sta; legal range 1..255.
- TIMEOUT, 64, maximum cycles in WAIT for done_sig; legal range 1..1023.
- WIDTH, 32, sample width (`SINGLE).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream sample strobe.
- in_data  in  WIDTH  upstream sample (float bits, passed through unmodified).
- in_ready  out  1  buffer can accept a sample.
- step  in  1  control-step start pulse.
- err_clr  in  1  clears sticky error flags.
- done_read_x  out  1  one-cycle pulse, LEAD cycles before sta.
- sta  out  1  one-cycle pulse, coincident with x word 0.
- x  out  WIDTH  sample stream to the integrator.
- done_sig  in  1  integrator result-stream start pulse.
- step_done  out  1  one-cycle pulse when the step completes.
- busy  out  1  step in progress.
- err_step  out  1  sticky: step rejected.
- err_timeout  out  1  sticky: done_sig missing.

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-low.
- Reset (rst=0): all outputs 0, FSM to FILL, write count 0, buffer contents don't-care. After release, in_ready is 1.
- FSM states: FILL, READY, LEAD, STREAM, WAIT, DRAIN.
- FILL:
  - in_ready=1.
  - in_valid && in_ready writes in_data to slot[wcnt], then wcnt++.
  - When wcnt reaches N, go to READY.
- READY:
  - in_ready=0; samples presented while in_ready=0 are dropped silently.
  - step → LEAD.
- LEAD:
  - done_read_x=1 in the first LEAD cycle only.
  - Stays LEAD cycles, then → STREAM.
- STREAM:
  - Lasts N cycles. Cycle k (k=0..N-1) drives x=slot[k]; sta=1 at k=0 only.
  - x=0 in every other state.
  - Then → WAIT.
- WAIT:
  - done_sig → DRAIN.
  - A cycle counter runs from entry. If TIMEOUT cycles elapse without done_sig: set err_timeout, clear wcnt, → FILL. No step_done is issued on this abort.
- DRAIN:
  - Lasts N cycles (the integrator result stream), then step_done=1 for one cycle.
  - wcnt cleared, → FILL.
- Cycle timing, with step sampled high at cycle t in READY:
  - done_read_x high at t+1.
  - sta high and x=slot[0] at t+1+LEAD.
  - slot[N-1] at t+LEAD+N.
- Completion timing: done_sig sampled at cycle d in WAIT gives step_done at d+N.
- busy=1 from t+1 through the step_done cycle inclusive, or through the timeout cycle.
- step in FILL (buffer not full) or in LEAD/STREAM/WAIT/DRAIN: ignored; err_step set.
- step in the same cycle as the Nth write: FILL is still active, so the step is rejected (err_step set).
- done_sig outside WAIT: ignored, no flag. done_sig in the same cycle as the timeout expiry: done_sig wins, → DRAIN, no err_timeout.
- err_clr clears both sticky flags. If err_clr coincides with a new error event, the set wins.
- rst asserted mid-step: immediate abort, with no trailing sta or step_done after release.
- Data path: no arithmetic; bits are passed through unchanged (NaN/denormal patterns preserved).

Test Plan:
- Fill and stream (N=4, LEAD=15): write 3F800000, 40000000, 40400000, 40800000, then step at t → done_read_x at t+1; sta at t+16; x = those four words at t+16..t+19; x=0 otherwise.
- Completion: done_sig at cycle d in WAIT → step_done at d+4; busy falls after that cycle; in_ready=1 next cycle; a new fill and step repeats the timing exactly.
- Rejects: step after 2 writes → err_step=1, no done_read_x. Then step during STREAM → err_step stays 1, stream unaffected. err_clr → flag 0.
- Backpressure: 6 consecutive in_valid with distinct words → only the first 4 are stored and streamed; words 5 and 6 are dropped.
- Timeout (TIMEOUT=64): no done_sig → err_timeout=1 at the 64th WAIT cycle, FSM back to FILL, no step_done. Separately, done_sig on that exact cycle → no error, step_done 4 cycles later.
- Reset mid-operation: drive rst=0 during LEAD → all outputs 0 immediately. After release, no sta or step_done appears and in_ready=1.
